// File: rtl/seg7_axi_regs_if.sv
// AXI4-Lite slave bus bundle for the seven-segment register block.
// Signal names follow the AXI port names of the 7seg IP.
interface seg7_axi_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/seg7_axi_regs.sv
// AXI4-Lite register block (CTRL, DIGITS, SCAN_DIV, MASK) driving a
// multiplexed, common-anode, active-low 4-digit seven-segment display.
module seg7_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  seg7_axi_regs_if.slave        s_axi,
  output logic [3:0]            an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [DW-1:0] rdata_q, rdata_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic          dp_n_q, dp_n_d;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [1:0] wsel, rsel;
  logic       unused_bits;

  assign awaddr      = s_axi.S_AXI_AWADDR;
  assign araddr      = s_axi.S_AXI_ARADDR;
  assign wsel        = awaddr[3:2];
  assign rsel        = araddr[3:2];
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};

  // ---------------- write channel ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) w_state_d = W_ACK;
      W_ACK:   w_state_d = W_RESP;
      W_RESP:  if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi.S_AXI_AWREADY = (w_state_q == W_ACK);
  assign s_axi.S_AXI_WREADY  = (w_state_q == W_ACK);
  assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = 2'b00;

  // Commit happens on the edge ending W_ACK, when both READYs are high.
  always_comb begin
    for (int r = 0; r < 4; r++) regs_d[r] = regs_q[r];
    if (w_state_q == W_ACK) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) regs_d[wsel][8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE:  if (s_axi.S_AXI_ARVALID) r_state_d = R_ACK;
      R_ACK: begin
        r_state_d = R_DATA;
        rdata_d   = regs_q[rsel];
      end
      R_DATA:  if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  assign s_axi.S_AXI_ARREADY = (r_state_q == R_ACK);
  assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  // ---------------- scan counter ----------------
  logic        enable, raw_mode;
  logic [15:0] div_m1;

  assign enable   = regs_q[0][0];
  assign raw_mode = regs_q[0][1];
  assign div_m1   = (regs_q[2][15:0] == 16'd0) ? 16'd0 : regs_q[2][15:0] - 16'd1;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q >= div_m1) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // ---------------- display ----------------
  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [3:0] nibble, dp_mask, blank_mask;
  logic [6:0] raw_seg;

  assign nibble     = regs_q[1][{idx_q, 2'b00} +: 4];
  assign raw_seg    = regs_q[1][{idx_q, 3'b000} +: 7];
  assign dp_mask    = regs_q[3][3:0];
  assign blank_mask = regs_q[3][7:4];

  always_comb begin
    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (enable && !blank_mask[idx_q]) begin
      an_n_d  = ~(4'b0001 << idx_q);
      seg_n_d = raw_mode ? ~raw_seg : hex7(nibble);
      dp_n_d  = ~dp_mask[idx_q];
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;

  // ---------------- state ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      an_n_q    <= 4'hF;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      // NOTE: the register file is only four words, so it is reset like any other flop.
      for (int r = 0; r < 4; r++) regs_q[r] <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      for (int r = 0; r < 4; r++) regs_q[r] <= regs_d[r];
    end
  end
endmodule

// File: tb/tb_seg7_axi_regs.sv
// Directed bench for seg7_axi_regs: bus responses go through a scoreboard
// queue checked by a monitor; display scans are compared against hand tables.
module tb_seg7_axi_regs;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_axi_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  seg7_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .s_axi   (bus.slave),
    .an_n    (an_n),
    .seg_n   (seg_n),
    .dp_n    (dp_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  exp_b [$];
  logic [31:0] exp_r [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge when VALID and READY are both high here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
      if (exp_b.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", bus.S_AXI_BRESP, exp_b.pop_front());
    end
    if (rst_n === 1'b1 && bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else check("rdata", {bus.S_AXI_RRESP, bus.S_AXI_RDATA}, {2'b00, exp_r.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic aw_w_start(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit expect_b);
    if (expect_b) exp_b.push_back(2'b00);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
  endtask

  task automatic aw_w_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 50);
    check("aw_w_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    while (!bus.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("b_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int n = 0;
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    while (!bus.S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("r_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    bus.S_AXI_BREADY = 1'b1;
    aw_w_start(a, d, s, 1'b1);
    aw_w_accept();
    wait_b();
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    int n = 0;
    exp_r.push_back(exp);
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < 50);
    check("ar_ready", bus.S_AXI_ARREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    wait_r();
  endtask

  // exp[i] = {an_n, seg_n, dp_n} while scan slot i is shown; per = cycles per slot.
  task automatic check_scan(input string name, input int per, input logic [3:0][11:0] exp);
    logic [3:0] prev;
    bit found = 1'b0;
    int n = 0;
    @(negedge clk);
    prev = an_n;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (an_n == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = an_n;
    end
    if (!found) check({name, "_sync"}, 0, 1);
    for (int k = 0; k < 5 * per; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s_%0d", name, k), {an_n, seg_n, dp_n}, exp[(k / per) % 4]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    check("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    check("rst_resp",  {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 4'b0000);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    check("rst_disp",  {an_n, seg_n, dp_n}, {4'hF, 7'h7F, 1'b1});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic register map
    axi_write(4'h0, 32'h1);
    axi_write(4'h4, 32'h2);
    axi_write(4'h8, 32'h3);
    axi_write(4'hC, 32'h4);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_read(4'hC, 32'h4);

    // Byte strobes
    axi_write(4'h4, 32'hFFFF_FFFF);
    axi_write(4'h4, 32'h0000_0012, 4'b0001);
    axi_read(4'h4, 32'hFFFF_FF12);
    axi_write(4'h4, 32'h00AB_0000, 4'b0100);
    axi_read(4'h4, 32'hFFAB_FF12);

    // Hex scan 0x1234, 2 cycles per digit
    axi_write(4'hC, 32'h0);
    axi_write(4'h4, 32'h1234);
    axi_write(4'h8, 32'h2);
    axi_write(4'h0, 32'h1);
    check_scan("hex1234", 2, {{4'b0111, 7'b1111001, 1'b1}, {4'b1011, 7'b0100100, 1'b1},
                              {4'b1101, 7'b0110000, 1'b1}, {4'b1110, 7'b0011001, 1'b1}});

    // Decimal point on digit 0, digit 1 blanked
    axi_write(4'hC, 32'h21);
    check_scan("mask21", 2, {{4'b0111, 7'b1111001, 1'b1}, {4'b1011, 7'b0100100, 1'b1},
                             {4'b1111, 7'b1111111, 1'b1}, {4'b1110, 7'b0011001, 1'b0}});

    axi_write(4'hC, 32'h0);
    axi_write(4'h4, 32'h5678);
    check_scan("hex5678", 2, {{4'b0111, 7'b0010010, 1'b1}, {4'b1011, 7'b0000010, 1'b1},
                              {4'b1101, 7'b1111000, 1'b1}, {4'b1110, 7'b0000000, 1'b1}});

    // SCAN_DIV = 0 behaves as 1 cycle per digit
    axi_write(4'h8, 32'h0);
    axi_write(4'h4, 32'h9ABC);
    check_scan("hex9abc", 1, {{4'b0111, 7'b0010000, 1'b1}, {4'b1011, 7'b0001000, 1'b1},
                              {4'b1101, 7'b0000011, 1'b1}, {4'b1110, 7'b1000110, 1'b1}});
    axi_write(4'h4, 32'hDEF0);
    check_scan("hexdef0", 1, {{4'b0111, 7'b0100001, 1'b1}, {4'b1011, 7'b0000110, 1'b1},
                              {4'b1101, 7'b0001110, 1'b1}, {4'b1110, 7'b1000000, 1'b1}});

    // Raw mode, bit 7 of each byte ignored, dp on digit 3
    axi_write(4'hC, 32'h8);
    axi_write(4'h4, 32'h8040_2A55);
    axi_write(4'h0, 32'h3);
    check_scan("raw", 1, {{4'b0111, 7'b1111111, 1'b0}, {4'b1011, 7'b0111111, 1'b1},
                          {4'b1101, 7'b1010101, 1'b1}, {4'b1110, 7'b0101010, 1'b1}});

    // Disabled
    axi_write(4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("disabled_disp", {an_n, seg_n, dp_n}, {4'hF, 7'h7F, 1'b1});

    // BREADY held low: response holds, next write waits
    bus.S_AXI_BREADY = 1'b0;
    aw_w_start(4'h4, 32'hCAFE_F00D, 4'hF, 1'b1);
    aw_w_accept();
    aw_w_start(4'h8, 32'h5, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bhold_valid_%0d", i), bus.S_AXI_BVALID, 1);
      check($sformatf("bhold_ready_%0d", i), {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
    end
    @(posedge clk); #1;
    wait_b();
    aw_w_accept();
    wait_b();
    axi_read(4'h4, 32'hCAFE_F00D);
    axi_read(4'h8, 32'h5);

    // Write commit and read capture on the same edge: read sees the old value
    bus.S_AXI_RREADY = 1'b0;
    aw_w_start(4'h8, 32'h77, 4'hF, 1'b1);
    exp_r.push_back(32'h5);
    bus.S_AXI_ARADDR  = 4'h8;
    bus.S_AXI_ARVALID = 1'b1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 50);
    end
    check("same_edge_ready", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b11);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    wait_b();
    wait_r();
    axi_read(4'h8, 32'h77);

    // Reset while the write response is pending
    axi_write(4'h0, 32'h1);
    bus.S_AXI_BREADY = 1'b0;
    aw_w_start(4'h8, 32'hDEAD_BEEF, 4'hF, 1'b0);
    aw_w_accept();
    @(negedge clk);
    check("pre_rst_bvalid", bus.S_AXI_BVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", bus.S_AXI_BVALID, 0);
    check("mid_rst_disp", {an_n, seg_n, dp_n}, {4'hF, 7'h7F, 1'b1});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    axi_read(4'h0, 32'h0);
    axi_read(4'h4, 32'h0);
    axi_read(4'h8, 32'h0);
    axi_read(4'hC, 32'h0);
    @(negedge clk);
    check("post_rst_disp", {an_n, seg_n, dp_n}, {4'hF, 7'h7F, 1'b1});

    repeat (2) @(negedge clk);
    check("sb_empty", exp_b.size() + exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
